// File: rtl/div_unit_pkg.sv
// Shared pipeline definitions: ALU control encodings consumed by the divider
// and the divider FSM state type.
package div_unit_pkg;

  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_DIV  = 8'h1A;
  localparam logic [7:0] ALU_DIVU = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  function automatic logic isDivOp(input logic [7:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring shift-subtract datapath: one quotient bit per step, with the
// next-step values exposed so the caller can capture the final step directly.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorReg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             noBorrow;

  // The shifted partial remainder needs one extra bit before the trial subtract.
  always_comb begin
    shifted  = {remReg, quoReg[WIDTH-1]};
    diff     = shifted - {1'b0, divisorReg};
    noBorrow = (shifted >= {1'b0, divisorReg});
    if (noBorrow) begin
      remNext = diff[WIDTH-1:0];
      quoNext = {quoReg[WIDTH-2:0], 1'b1};
    end else begin
      remNext = shifted[WIDTH-1:0];
      quoNext = {quoReg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
    end else if (load) begin
      remReg     <= '0;
      quoReg     <= dividend;
      divisorReg <= divisor;
    end else if (step) begin
      remReg <= remNext;
      quoReg <= quoNext;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Execute-stage iterative divider: sign pre-processing, WIDTH restoring steps,
// sign fix-up, and the stall/ready handshake with the pipeline.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           alucontrolE,
  input  logic [WIDTH-1:0]     srcaE,
  input  logic [WIDTH-1:0]     srcbE,
  input  logic                 flushE,
  input  logic                 stallE,
  output logic                 stall_divE,
  output logic                 div_readyE,
  output logic [2*WIDTH-1:0]   hilo_divE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  divState_t        state;
  logic [CW-1:0]    count;
  logic             quoNeg;
  logic             remNeg;
  logic             byZero;
  logic             readyReg;
  logic [2*WIDTH-1:0] hiloReg;

  logic             startOp;
  logic             signedOp;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] fixQuo;
  logic [WIDTH-1:0] fixRem;

  // Operands are reduced to magnitudes so the core only ever divides unsigned.
  always_comb begin
    startOp  = (state == IDLE) && isDivOp(alucontrolE) && !flushE;
    signedOp = (alucontrolE == ALU_DIV);
    aNeg     = signedOp && srcaE[WIDTH-1];
    bNeg     = signedOp && srcbE[WIDTH-1];
    absA     = aNeg ? (~srcaE + 1'b1) : srcaE;
    absB     = bNeg ? (~srcbE + 1'b1) : srcbE;
  end

  // Divide-by-zero forces an all-ones quotient; the remainder magnitude is then
  // |dividend|, which the dividend-sign fix-up turns back into the original value.
  always_comb begin
    fixRem = remNeg ? (~remNext + 1'b1) : remNext;
    if (byZero) begin
      fixQuo = '1;
    end else begin
      fixQuo = quoNeg ? (~quoNext + 1'b1) : quoNext;
    end
  end

  div_iter #(.WIDTH(WIDTH)) uIter (
    .clk      (clk),
    .rst      (rst),
    .load     (startOp),
    .step     ((state == BUSY) && !flushE),
    .dividend (absA),
    .divisor  (absB),
    .remNext  (remNext),
    .quoNext  (quoNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      quoNeg   <= 1'b0;
      remNeg   <= 1'b0;
      byZero   <= 1'b0;
      readyReg <= 1'b0;
      hiloReg  <= '0;
    end else if (flushE) begin
      state    <= IDLE;
      count    <= '0;
      readyReg <= 1'b0;
      hiloReg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startOp) begin
            state  <= BUSY;
            count  <= '0;
            quoNeg <= aNeg ^ bNeg;
            remNeg <= aNeg;
            byZero <= (srcbE == '0);
          end
        end
        BUSY: begin
          count <= count + 1'b1;
          if (count == LAST) begin
            state    <= DONE;
            readyReg <= 1'b1;
            hiloReg  <= {fixRem, fixQuo};
          end
        end
        DONE: begin
          if (!stallE) begin
            state    <= IDLE;
            readyReg <= 1'b0;
            hiloReg  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates the Mealy stall so every output reads 0 while reset is held.
  assign stall_divE = rst && (startOp || ((state == BUSY) && !flushE));
  assign div_readyE = readyReg;
  assign hilo_divE  = hiloReg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a cycle-level expectation timeline checked on
// every falling edge, plus literal checks of each finished result.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  alucontrolE = ALU_NOP;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        flushE = 1'b0;
  logic        stallE = 1'b0;
  logic        stall_divE;
  logic        div_readyE;
  logic [63:0] hilo_divE;

  int compared = 0;
  int mismatched = 0;
  logic checkEn = 1'b0;
  logic expStall = 1'b0;
  logic expReady = 1'b0;
  logic [63:0] expHilo = '0;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alucontrolE (alucontrolE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .flushE      (flushE),
    .stallE      (stallE),
    .stall_divE  (stall_divE),
    .div_readyE  (div_readyE),
    .hilo_divE   (hilo_divE)
  );

  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from plain arithmetic and the divide rules.
  function automatic logic [63:0] modelDiv(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (op == ALU_DIV) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = 32'h80000000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall_divE", 64'(stall_divE), 64'(expStall));
      checkOutput("div_readyE", 64'(div_readyE), 64'(expReady));
      checkOutput("hilo_divE", hilo_divE, expHilo);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setExp(input logic s, input logic r, input logic [63:0] h);
    expStall = s;
    expReady = r;
    expHilo  = h;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      alucontrolE = ALU_NOP;
      flushE = 1'b0;
      stallE = 1'b0;
      setExp(1'b0, 1'b0, 64'd0);
    end
  endtask

  // Full divide: detect cycle, WIDTH busy cycles, then hold+1 DONE cycles.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input logic [63:0] lit);
    checkOutput("modelPin", modelDiv(op, a, b), lit);
    nextCycle();
    alucontrolE = op;
    srcaE = a;
    srcbE = b;
    flushE = 1'b0;
    stallE = 1'b0;
    setExp(1'b1, 1'b0, 64'd0);
    for (int i = 1; i <= WIDTH; i++) begin
      nextCycle();
      setExp(1'b1, 1'b0, 64'd0);
    end
    for (int i = 0; i <= hold; i++) begin
      nextCycle();
      stallE = (i < hold);
      setExp(1'b0, 1'b1, modelDiv(op, a, b));
      if (i == 0) begin
        @(negedge clk);
        checkOutput("literal", hilo_divE, lit);
      end
    end
  endtask

  task automatic flushInBusy(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int atBusy);
    nextCycle();
    alucontrolE = op;
    srcaE = a;
    srcbE = b;
    flushE = 1'b0;
    stallE = 1'b0;
    setExp(1'b1, 1'b0, 64'd0);
    for (int i = 1; i < atBusy; i++) begin
      nextCycle();
      setExp(1'b1, 1'b0, 64'd0);
    end
    nextCycle();
    flushE = 1'b1;
    setExp(1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting div_unit bench");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetStall", 64'(stall_divE), 64'd0);
    checkOutput("resetReady", 64'(div_readyE), 64'd0);
    checkOutput("resetHilo", hilo_divE, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    checkEn = 1'b1;
    idleCycles(2);

    applyStimulus(ALU_DIVU, 32'd100, 32'd7, 0, 64'h00000002_0000000E);
    applyStimulus(ALU_DIV, 32'hFFFFFFF9, 32'd2, 0, 64'hFFFFFFFF_FFFFFFFD);
    idleCycles(1);
    applyStimulus(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 64'h00000000_80000000);
    applyStimulus(ALU_DIVU, 32'h00001234, 32'd0, 0, 64'h00001234_FFFFFFFF);
    applyStimulus(ALU_DIV, 32'h80000000, 32'd0, 0, 64'h80000000_FFFFFFFF);
    applyStimulus(ALU_DIV, 32'hFFFFFFFB, 32'd0, 0, 64'hFFFFFFFB_FFFFFFFF);
    applyStimulus(ALU_DIV, 32'd7, 32'hFFFFFFFE, 0, 64'h00000001_FFFFFFFD);
    applyStimulus(ALU_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 0, 64'hFFFFFFFE_0000000E);
    applyStimulus(ALU_DIVU, 32'hFFFFFFFF, 32'd1, 0, 64'h00000000_FFFFFFFF);
    applyStimulus(ALU_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'h00000000_00000001);
    idleCycles(2);

    // Flush in busy cycle 10, then a new divide straight from IDLE.
    flushInBusy(ALU_DIV, 32'd12345, 32'd17, 10);
    applyStimulus(ALU_DIVU, 32'd9, 32'd4, 0, 64'h00000001_00000002);
    idleCycles(1);

    // Divide op arriving together with a flush must not start.
    nextCycle();
    alucontrolE = ALU_DIV;
    srcaE = 32'd50;
    srcbE = 32'd5;
    flushE = 1'b1;
    setExp(1'b0, 1'b0, 64'd0);
    idleCycles(3);

    // Hold at DONE for three cycles, then a back-to-back DIVU.
    applyStimulus(ALU_DIVU, 32'd1000, 32'd10, 3, 64'h00000000_00000064);
    applyStimulus(ALU_DIVU, 32'd77, 32'd5, 0, 64'h00000002_0000000F);
    idleCycles(1);

    // Asynchronous reset in the middle of a divide.
    nextCycle();
    alucontrolE = ALU_DIV;
    srcaE = 32'd999;
    srcbE = 32'd3;
    setExp(1'b1, 1'b0, 64'd0);
    for (int i = 1; i <= 15; i++) begin
      nextCycle();
      setExp(1'b1, 1'b0, 64'd0);
    end
    checkEn = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncRstStall", 64'(stall_divE), 64'd0);
    checkOutput("asyncRstReady", 64'(div_readyE), 64'd0);
    checkOutput("asyncRstHilo", hilo_divE, 64'd0);
    nextCycle();
    alucontrolE = ALU_NOP;
    setExp(1'b0, 1'b0, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    checkEn = 1'b1;
    idleCycles(2);
    applyStimulus(ALU_DIV, 32'd999, 32'd3, 0, 64'h00000000_0000014D);
    idleCycles(2);

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
